// File: rtl/nios_usb_ctrl_pkg.sv
// nios_usb_ctrl_pkg: register map, STATUS bit positions and pulse FSM states
//   shared by the USB control output port and its pulse timer.
package nios_usb_ctrl_pkg;
  localparam logic [2:0] ADDR_DATA      = 3'd0;
  localparam logic [2:0] ADDR_SET       = 3'd1;
  localparam logic [2:0] ADDR_CLEAR     = 3'd2;
  localparam logic [2:0] ADDR_PULSE_LEN = 3'd3;
  localparam logic [2:0] ADDR_PULSE_GO  = 3'd4;
  localparam logic [2:0] ADDR_STATUS    = 3'd5;
  localparam int ST_BUSY    = 0;
  localparam int ST_DONE    = 1;
  localparam int ST_OVERRUN = 2;
  typedef enum logic {S_IDLE, S_ACTIVE} state_t;
endpackage

// File: rtl/nios_usb_pulse_timer.sv
// nios_usb_pulse_timer: one-shot cycle timer; load with nonzero len starts it,
//   busy holds for len cycles and expire flags the final busy cycle.
//   clk, reset_n : clock, async active-low reset
//   load         : start request (ignored while busy or when len is 0)
//   len          : number of cycles to stay busy
//   busy         : timer running
//   expire       : last running cycle; timer returns to idle on this edge
module nios_usb_pulse_timer
  import nios_usb_ctrl_pkg::*;
#(
  parameter int LEN_W = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             load,
  input  logic [LEN_W-1:0] len,
  output logic             busy,
  output logic             expire
);
  state_t state, state_nx;
  logic [LEN_W-1:0] cnt, cnt_nx;
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  // The count runs down to 1 and stops there, so it never wraps.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    if (state == S_IDLE) begin
      if (load && len != '0) begin
        state_nx = S_ACTIVE;
        cnt_nx   = len;
      end
    end else if (cnt == LEN_W'(1)) begin
      state_nx = S_IDLE;
      cnt_nx   = '0;
    end else begin
      cnt_nx = cnt - LEN_W'(1);
    end
  end
  always_comb begin
    busy   = state == S_ACTIVE;
    expire = state == S_ACTIVE && cnt == LEN_W'(1);
  end
endmodule

// File: rtl/nios_usb_ctrl_out.sv
// nios_usb_ctrl_out: Avalon-MM output port driving USB controller control lines,
//   with data/set/clear registers and a hardware-timed toggle pulse.
//   clk, reset_n       : clock, async active-low reset
//   address            : word address (0 DATA,1 SET,2 CLEAR,3 PULSE_LEN,4 PULSE_GO,5 STATUS)
//   chipselect,write_n : write = chipselect & ~write_n
//   writedata          : write data (low WIDTH / LEN_W bits used)
//   readdata           : registered read data, one cycle after address
//   out_port           : registered DATA ^ active pulse mask
module nios_usb_ctrl_out
  import nios_usb_ctrl_pkg::*;
#(
  parameter int               WIDTH       = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int               LEN_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [2:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  output logic [WIDTH-1:0] out_port
);
  logic [WIDTH-1:0] data, data_nx, mask, mask_nx, wd;
  logic [LEN_W-1:0] pulse_len, pulse_len_nx;
  logic             done, done_nx, overrun, overrun_nx;
  logic             wr, go, start, zero_go, st_wr, busy, expire;
  logic [31:0]      rd_nx;
  logic             unused_wd;
  assign unused_wd = ^writedata;
  assign wd        = writedata[WIDTH-1:0];
  nios_usb_pulse_timer #(.LEN_W(LEN_W)) u_timer (
    .clk    (clk),
    .reset_n(reset_n),
    .load   (go),
    .len    (pulse_len),
    .busy   (busy),
    .expire (expire)
  );
  // A GO while a pulse runs is dropped and only flagged as overrun; a GO with a
  // zero length completes immediately without toggling anything.
  always_comb begin
    wr           = chipselect & ~write_n;
    go           = wr && address == ADDR_PULSE_GO;
    st_wr        = wr && address == ADDR_STATUS;
    start        = go && !busy && pulse_len != '0;
    zero_go      = go && !busy && pulse_len == '0;
    data_nx      = !wr                     ? data :
                   address == ADDR_DATA    ? wd :
                   address == ADDR_SET     ? data | wd :
                   address == ADDR_CLEAR   ? data & ~wd : data;
    pulse_len_nx = wr && address == ADDR_PULSE_LEN ? writedata[LEN_W-1:0] : pulse_len;
    mask_nx      = expire ? '0 : start ? wd : mask;
    done_nx      = (done & ~(st_wr & writedata[ST_DONE])) | expire | zero_go;
    overrun_nx   = (overrun & ~(st_wr & writedata[ST_OVERRUN])) | (go & busy);
    rd_nx        = address == ADDR_DATA      ? 32'(data) :
                   address == ADDR_PULSE_LEN ? 32'(pulse_len) :
                   address == ADDR_STATUS    ? {29'b0, overrun, done, busy} : '0;
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      data      <= RESET_VALUE;
      mask      <= '0;
      pulse_len <= '0;
      done      <= 1'b0;
      overrun   <= 1'b0;
      readdata  <= '0;
      out_port  <= RESET_VALUE;
    end else begin
      data      <= data_nx;
      mask      <= mask_nx;
      pulse_len <= pulse_len_nx;
      done      <= done_nx;
      overrun   <= overrun_nx;
      readdata  <= rd_nx;
      out_port  <= data ^ mask;
    end
endmodule
